// File: rtl/qm_icache_pkg.sv
// Shared geometry and refill FSM encoding for the qm instruction cache.
package qm_icache_pkg;
  localparam int QM_INDEX_BITS  = 6;
  localparam int QM_OFFSET_BITS = 2;
  localparam int QM_TAG_BITS    = 30 - QM_INDEX_BITS - QM_OFFSET_BITS;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } refill_state_e;
endpackage

// File: rtl/qm_icache_refill.sv
// Line refill engine: latches the missing line, walks words 0..N-1 through
// the req/ack handshake and reports when the line may be marked valid.
module qm_icache_refill
  import qm_icache_pkg::*;
#(
  parameter int INDEX_BITS  = QM_INDEX_BITS,
  parameter int OFFSET_BITS = QM_OFFSET_BITS,
  localparam int LINE_BITS  = 30 - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LINE_BITS-1:0]   line_addr,
  input  logic                   flush,
  input  logic                   mem_ack,
  output logic                   busy,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  output logic                   wr_en,
  output logic [OFFSET_BITS-1:0] wr_word,
  output logic                   fill_done,
  output logic                   fill_valid,
  output logic [LINE_BITS-1:0]   fill_line
);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = {OFFSET_BITS{1'b1}};

  refill_state_e          state_r;
  logic [LINE_BITS-1:0]   line_r;
  logic [OFFSET_BITS-1:0] cnt_r;
  logic [OFFSET_BITS-1:0] cnt_next_s;
  logic                   mem_req_r;
  logic [31:0]            mem_addr_r;
  logic                   flush_pend_r;

  assign cnt_next_s = cnt_r + OFFSET_BITS'(1);

  // Refill FSM, word counter, handshake outputs and flush-during-refill memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      line_r       <= '0;
      cnt_r        <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'h0;
      flush_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_REFILL;
            line_r       <= line_addr;
            cnt_r        <= '0;
            mem_req_r    <= 1'b1;
            mem_addr_r   <= {line_addr, {OFFSET_BITS{1'b0}}, 2'b00};
            flush_pend_r <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            if (cnt_r == LAST_WORD) begin
              state_r      <= ST_IDLE;
              cnt_r        <= '0;
              mem_req_r    <= 1'b0;
              flush_pend_r <= 1'b0;
            end else begin
              cnt_r      <= cnt_next_s;
              mem_addr_r <= {line_r, cnt_next_s, 2'b00};
              if (flush) begin
                flush_pend_r <= 1'b1;
              end
            end
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (state_r == ST_REFILL);
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign wr_en      = busy && mem_ack;
  assign wr_word    = cnt_r;
  assign fill_done  = wr_en && (cnt_r == LAST_WORD);
  // A flush seen at any point of the refill, including the last ack, keeps the line invalid
  assign fill_valid = fill_done && !flush && !flush_pend_r;
  assign fill_line  = line_r;
endmodule

// File: rtl/qm_icache.sv
// Direct-mapped instruction cache: asynchronous-read data/tag arrays with a
// valid vector; misses are serviced by qm_icache_refill one line at a time.
module qm_icache
  import qm_icache_pkg::*;
#(
  parameter int INDEX_BITS  = QM_INDEX_BITS,
  parameter int OFFSET_BITS = QM_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] icache_address,
  output logic        icache_hit,
  output logic        icache_should_stall,
  output logic [31:0] icache_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int TAG_BITS  = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORDS     = 1 << (INDEX_BITS + OFFSET_BITS);
  localparam int LINE_BITS = TAG_BITS + INDEX_BITS;

  logic [31:0]            data_mem_r [WORDS];
  logic [TAG_BITS-1:0]    tag_mem_r  [LINES];
  logic [LINES-1:0]       valid_r;

  logic [TAG_BITS-1:0]    addr_tag_s;
  logic [INDEX_BITS-1:0]  idx_s;
  logic [OFFSET_BITS-1:0] off_s;
  logic [1:0]             addr_unused_s;
  logic                   hit_s;
  logic [31:0]            data_s;
  logic                   start_s;

  logic                   busy_s;
  logic                   wr_en_s;
  logic [OFFSET_BITS-1:0] wr_word_s;
  logic                   fill_done_s;
  logic                   fill_valid_s;
  logic [LINE_BITS-1:0]   fill_line_s;
  logic [INDEX_BITS-1:0]  fill_idx_s;
  logic [TAG_BITS-1:0]    fill_tag_s;

  assign addr_tag_s    = icache_address[31 -: TAG_BITS];
  assign idx_s         = icache_address[2+OFFSET_BITS +: INDEX_BITS];
  assign off_s         = icache_address[2 +: OFFSET_BITS];
  assign addr_unused_s = icache_address[1:0];
  assign fill_idx_s    = fill_line_s[INDEX_BITS-1:0];
  assign fill_tag_s    = fill_line_s[LINE_BITS-1:INDEX_BITS];

  // Combinational lookup; a flush in the same cycle forces a miss
  always_comb begin
    hit_s  = 1'b0;
    data_s = 32'h0;
    if (!busy_s && valid_r[idx_s] && (tag_mem_r[idx_s] == addr_tag_s) && !flush) begin
      hit_s  = 1'b1;
      data_s = data_mem_r[{idx_s, off_s}];
    end else begin
      hit_s  = 1'b0;
      data_s = 32'h0;
    end
  end

  assign icache_hit          = hit_s;
  assign icache_should_stall = ~hit_s;
  assign icache_data         = data_s;
  assign start_s             = !hit_s && !flush;

  qm_icache_refill #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_refill (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_s),
    .line_addr  ({addr_tag_s, idx_s}),
    .flush      (flush),
    .mem_ack    (mem_ack),
    .busy       (busy_s),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .wr_en      (wr_en_s),
    .wr_word    (wr_word_s),
    .fill_done  (fill_done_s),
    .fill_valid (fill_valid_s),
    .fill_line  (fill_line_s)
  );

  // Valid vector: flush wins over a completing refill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (fill_valid_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data and tag arrays carry no reset; the valid vector guards them
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_mem_r[{fill_idx_s, wr_word_s}] <= mem_data;
    end
    if (fill_done_s) begin
      tag_mem_r[fill_idx_s] <= fill_tag_s;
    end
  end
endmodule

// File: tb/tb_qm_icache.sv
// Scoreboarded bench for qm_icache: expected refill addresses are queued when
// a miss is driven and popped by the memory responder on every ack.
module tb_qm_icache;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] icache_address;
  logic        icache_hit;
  logic        icache_should_stall;
  logic [31:0] icache_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int          n_total = 0;
  int          n_pass  = 0;
  int          ack_gap = 1;
  int          wait_cnt = 0;
  bit          stray = 1'b0;
  logic [31:0] exp_addr_q [$];

  qm_icache dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_address      (icache_address),
    .icache_hit          (icache_hit),
    .icache_should_stall (icache_should_stall),
    .icache_data         (icache_data),
    .flush               (flush),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ack             (mem_ack),
    .mem_data            (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [1:0] wi;
    for (int w = 0; w < 4; w++) begin
      wi = w[1:0];
      exp_addr_q.push_back({a[31:4], wi, 2'b00});
    end
  endtask

  // Memory responder: acks every ack_gap-th request cycle, pops and checks addresses
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (exp_addr_q.size() == 0) begin
        chk("extra_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1;
        mem_data = mem_word(mem_addr);
        wait_cnt = 0;
      end else if (wait_cnt >= ack_gap) begin
        chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
        wait_cnt = 0;
      end else begin
        chk("mem_addr_hold", mem_addr, exp_addr_q[0]);
        mem_ack = 1'b0;
      end
    end else begin
      wait_cnt = 0;
      mem_ack  = stray;
      mem_data = 32'hDEAD_BEEF;
    end
  end

  // Waits (bounded) for a hit on address a, counting stall cycles from the current one
  task automatic wait_hit(input logic [31:0] a, input int exp_stall, input string tag);
    int n;
    int bad;
    bit done;
    n = 0;
    bad = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (icache_should_stall !== ~icache_hit) bad++;
      if (icache_hit === 1'b1) begin
        done = 1'b1;
      end else if (n >= 200) begin
        chk({tag, "_timeout"}, {31'd0, icache_hit}, 32'd1);
        done = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
    chk({tag, "_data"}, icache_data, mem_word(a));
    chk({tag, "_stall_inv"}, 32'(bad), 32'd0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_queue"}, 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input int exp_stall, input string tag);
    icache_address = a;
    if (miss) push_line(a);
    wait_hit(a, exp_stall, tag);
  endtask

  task automatic wait_mem_addr(input logic [31:0] a, input string tag);
    int k;
    k = 0;
    while (!(mem_req === 1'b1 && mem_addr === a) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, mem_addr, a);
  endtask

  initial begin
    reset_n        = 1'b0;
    flush          = 1'b0;
    icache_address = 32'h0000_1000;
    mem_ack        = 1'b0;
    mem_data       = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_hit", {31'd0, icache_hit}, 32'd0);
    chk("rst_stall", {31'd0, icache_should_stall}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", icache_data, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    fetch(32'h0000_1000, 1'b1, 5, "cold");
    fetch(32'h0000_1004, 1'b0, 0, "hit_w1");
    fetch(32'h0000_100C, 1'b0, 0, "hit_w3");
    fetch(32'h0000_1400, 1'b1, 5, "replace");
    fetch(32'h0000_1000, 1'b1, 5, "evicted");

    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h0000_1000 + 32'(i * 4), 1'b0, 0, "stray_ack");
    end
    stray = 1'b0;

    ack_gap = 3;
    fetch(32'h0000_5000, 1'b1, 13, "slow");
    ack_gap = 1;
    for (int i = 1; i < 4; i++) begin
      fetch(32'h0000_5000 + 32'(i * 4), 1'b0, 0, "slow_word");
    end

    icache_address = 32'h0000_6000;
    push_line(32'h0000_6000);
    wait_mem_addr(32'h0000_600C, "flush_reach");
    flush = 1'b1;
    @(negedge clk);
    chk("flush_last_hit", {31'd0, icache_hit}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(32'h0000_6000, 1'b1, 5, "flush_refetch");

    icache_address = 32'h0000_6004;
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_hit", {31'd0, icache_hit}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_flush_noreq", {31'd0, mem_req}, 32'd0);
    flush = 1'b0;
    fetch(32'h0000_6004, 1'b1, 5, "post_flush");

    icache_address = 32'h0000_8000;
    push_line(32'h0000_8000);
    wait_mem_addr(32'h0000_8004, "rst_mid_reach");
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_hit", {31'd0, icache_hit}, 32'd0);
    chk("rst_mid_stall", {31'd0, icache_should_stall}, 32'd1);
    exp_addr_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fetch(32'h0000_8000, 1'b1, 5, "rst_restart");

    icache_address = 32'h0000_2000;
    push_line(32'h0000_2000);
    push_line(32'h0000_3000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    icache_address = 32'h0000_3000;
    wait_hit(32'h0000_3000, 8, "addr_change");
    fetch(32'h0000_2000, 1'b1, 5, "addr_change_old");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
